// File: rtl/rom_arbiter.sv
// rom_arbiter: two-master arbiter and access sequencer for the 16 KB program ROM.
// Latency: a request seen at grant edge E0 returns ack at E2 with nominal ROM (one access per 4 cycles).
// Backpressure: requests are level-held; a master waits in IDLE until granted, and there is no abort once granted.
//
// Ports:
//   xsoc_rom_clock, reset          - clock, synchronous active-high reset
//   m0_req/m0_addr -> m0_ack/m0_rdata/m0_err  - instruction-fetch master
//   m1_req/m1_addr -> m1_ack/m1_rdata/m1_err  - data-bus/debug master
//   rom_addr, rom_cs_, rom_as_     - ROM address and active-low strobes
//   rom_rdy_, rom_data             - ROM registered ready (active low) and read data
//   busy                           - high whenever the sequencer is not idle
module rom_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              xsoc_rom_clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_cs_,
  output logic              rom_as_,
  input  logic              rom_rdy_,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Last cycle of the rdy_ wait window; the counter starts at 0 on the grant edge.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  // last_grant also identifies the master owning the access in flight (0 = m0, 1 = m1).
  logic              last_grant_q, last_grant_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [ADDR_W-1:0] rom_addr_d;
  logic              rom_cs_d, rom_as_d, busy_d;
  logic              m0_ack_d, m0_err_d, m1_ack_d, m1_err_d;
  logic [DATA_W-1:0] m0_rdata_d, m1_rdata_d;

  logic              grant_m1;
  logic              fin;
  logic              fin_err;
  logic [DATA_W-1:0] fin_data;

  always_ff @(posedge xsoc_rom_clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      rom_addr     <= '0;
      rom_cs_      <= 1'b1;
      rom_as_      <= 1'b1;
      busy         <= 1'b0;
      m0_ack       <= 1'b0;
      m0_err       <= 1'b0;
      m0_rdata     <= '0;
      m1_ack       <= 1'b0;
      m1_err       <= 1'b0;
      m1_rdata     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rom_addr     <= rom_addr_d;
      rom_cs_      <= rom_cs_d;
      rom_as_      <= rom_as_d;
      busy         <= busy_d;
      m0_ack       <= m0_ack_d;
      m0_err       <= m0_err_d;
      m0_rdata     <= m0_rdata_d;
      m1_ack       <= m1_ack_d;
      m1_err       <= m1_err_d;
      m1_rdata     <= m1_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rom_addr_d   = rom_addr;
    rom_cs_d     = rom_cs_;
    rom_as_d     = rom_as_;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_err_d     = m0_err;
    m1_err_d     = m1_err;
    m0_rdata_d   = m0_rdata;
    m1_rdata_d   = m1_rdata;
    grant_m1     = 1'b0;
    fin          = 1'b0;
    fin_err      = 1'b0;
    fin_data     = '0;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On conflict the master that did not win last time goes first.
          grant_m1     = m1_req && (!m0_req || !last_grant_q);
          last_grant_d = grant_m1;
          rom_addr_d   = grant_m1 ? m1_addr : m0_addr;
          rom_cs_d     = 1'b0;
          rom_as_d     = 1'b0;
          cnt_d        = '0;
          state_d      = ACCESS;
        end
      end

      ACCESS: begin
        if (!rom_rdy_) begin
          fin      = 1'b1;
          fin_data = rom_data;
        end else if (cnt_q == TO_LAST) begin
          fin      = 1'b1;
          fin_err  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end

        if (fin) begin
          rom_cs_d = 1'b1;
          rom_as_d = 1'b1;
          state_d  = DONE;
          if (last_grant_q) begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = fin_data;
            m1_err_d   = fin_err;
          end else begin
            m0_ack_d   = 1'b1;
            m0_rdata_d = fin_data;
            m0_err_d   = fin_err;
          end
        end
      end

      // Requests are deliberately ignored here so a master can drop req on its ack.
      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule
